// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Shared constants and helpers for the frame-write ordering controller.
//   ADDR_W_DEF       default DDR address width
//   BANK_STRIDE_DEF  default address distance between frame banks
//   CH_OFFSET_DEF    default per-channel offsets inside a bank (ch0 in LSBs)
//   bankWidth()      width of a bank index: clog2(n) with a minimum of 1
// ---------------------------------------------------------------------------
package frame_pkg;

  localparam int ADDR_W_DEF = 28;

  localparam logic [27:0] BANK_STRIDE_DEF = 28'h010_0000;

  localparam logic [111:0] CH_OFFSET_DEF = {28'h003_8680, 28'h003_8400,
                                            28'h000_0280, 28'h000_0000};

  // A two-bank design still needs one bit to tell the banks apart.
  function automatic int bankWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vs_sync_edge.sv
// ---------------------------------------------------------------------------
// vs_sync_edge
// Brings one raw VSYNC line into the clk_i domain and emits a single-cycle
// pulse for each rising edge.
//   clk_i   sampling clock
//   rst_ni  asynchronous active-low reset
//   vs_i    raw VSYNC, asynchronous to clk_i
//   pos_o   registered one-cycle rising-edge pulse
// Latency: a rise captured at edge t produces pos_o high after edge t+2.
// ---------------------------------------------------------------------------
module vs_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vs_i,
  output logic pos_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pos_q;

  // Two metastability stages, then a history bit and a registered edge pulse
  // so the consumer sees a clean, glitch-free strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pos_q   <= 1'b0;
    end else begin
      sync1_q <= vs_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pos_q   <= sync2_q & ~prev_q;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/frame_order_gen_n.sv
// ---------------------------------------------------------------------------
// frame_order_gen_n
// Frame-write ordering controller. Each enabled channel's VSYNC raises a
// one-frame write request; once every enabled channel has completed its
// frame the write bank rotates through BUF_NUM banks and the finished bank
// is published to the read side.
//
// Ports
//   axi_aclk          sole clock
//   axi_aresetn       asynchronous active-low reset
//   img_vs            raw per-channel VSYNC (asynchronous)
//   ch_en             channel enable mask, sampled only at frame boundaries
//   write_req         per-channel level request to the write masters
//   write_done        per-channel one-cycle completion pulse
//   write_start_addr  per-channel start address in the current write bank
//   write_bank        bank currently being written
//   read_bank         last fully written bank
//   read_valid        set once the first bank has completed
//   frame_swap        one-cycle pulse on every bank rotation
//   drop_cnt          per-channel saturating dropped-VSYNC counters
//
// Build option: define FRAME_DROP_CNT_EN to add the drop_cnt port and its
// counters; without it the port and logic are absent.
// ---------------------------------------------------------------------------
module frame_order_gen_n
  import frame_pkg::*;
#(
  parameter int                         CH_NUM      = 4,
  parameter int                         BUF_NUM     = 2,
  parameter int                         ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]          BANK_STRIDE = BANK_STRIDE_DEF,
  parameter logic [CH_NUM*ADDR_W-1:0]   CH_OFFSET   = CH_OFFSET_DEF,
  localparam int                        BANK_W      = bankWidth(BUF_NUM)
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic [CH_NUM-1:0]          img_vs,
  input  logic [CH_NUM-1:0]          ch_en,
  output logic [CH_NUM-1:0]          write_req,
  input  logic [CH_NUM-1:0]          write_done,
  output logic [CH_NUM*ADDR_W-1:0]   write_start_addr,
  output logic [BANK_W-1:0]          write_bank,
  output logic [BANK_W-1:0]          read_bank,
  output logic                       read_valid,
  output logic                       frame_swap
`ifdef FRAME_DROP_CNT_EN
  ,
  output logic [CH_NUM*8-1:0]        drop_cnt
`endif
);

  logic [CH_NUM-1:0] vsPos;

  logic [CH_NUM-1:0] writeReq_q,  writeReq_d;
  logic [CH_NUM-1:0] doneMask_q,  doneMask_d;
  logic [CH_NUM-1:0] enMask_q,    enMask_d;
  logic [BANK_W-1:0] writeBank_q, writeBank_d;
  logic [BANK_W-1:0] readBank_q,  readBank_d;
  logic              readValid_q, readValid_d;
  logic              frameSwap_q, frameSwap_d;

  logic              allDone;
  logic [CH_NUM-1:0] acceptDone;
  logic [CH_NUM-1:0] maskAfterSwap;
  logic [CH_NUM-1:0] setReq;

  // One synchroniser/edge detector per channel.
  for (genvar g = 0; g < CH_NUM; g++) begin : gSync
    vs_sync_edge uSync (
      .clk_i  (axi_aclk),
      .rst_ni (axi_aresetn),
      .vs_i   (img_vs[g]),
      .pos_o  (vsPos[g])
    );
  end

  // Request/completion bookkeeping and bank rotation. A swap clears the done
  // mask in the same cycle it is taken, so a VSYNC arriving on that cycle is
  // judged against the fresh bank. Only dones that answer an outstanding
  // request count; the same qualified done is what clears the request, so a
  // stray done can never cancel a new request.
  always_comb begin
    allDone       = (&(doneMask_q | ~enMask_q)) && (|enMask_q);
    acceptDone    = write_done & writeReq_q;
    maskAfterSwap = allDone ? '0 : doneMask_q;
    setReq        = vsPos & enMask_q & ~maskAfterSwap & ~writeReq_q;

    writeReq_d    = (writeReq_q | setReq) & ~acceptDone;
    doneMask_d    = maskAfterSwap | acceptDone;

    enMask_d      = enMask_q;
    if (allDone || ((doneMask_q == '0) && (writeReq_q == '0))) begin
      enMask_d = ch_en;
    end

    writeBank_d   = writeBank_q;
    readBank_d    = readBank_q;
    readValid_d   = readValid_q;
    frameSwap_d   = allDone;
    if (allDone) begin
      writeBank_d = (writeBank_q == BANK_W'(BUF_NUM - 1)) ? '0 : writeBank_q + 1'b1;
      readBank_d  = writeBank_q;
      readValid_d = 1'b1;
    end
  end

  // State registers; reset returns the whole controller to bank 0 at once.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      writeReq_q  <= '0;
      doneMask_q  <= '0;
      enMask_q    <= '0;
      writeBank_q <= '0;
      readBank_q  <= '0;
      readValid_q <= 1'b0;
      frameSwap_q <= 1'b0;
    end else begin
      writeReq_q  <= writeReq_d;
      doneMask_q  <= doneMask_d;
      enMask_q    <= enMask_d;
      writeBank_q <= writeBank_d;
      readBank_q  <= readBank_d;
      readValid_q <= readValid_d;
      frameSwap_q <= frameSwap_d;
    end
  end

  // Start address is derived straight from the registered bank index.
  for (genvar g = 0; g < CH_NUM; g++) begin : gAddr
    assign write_start_addr[g*ADDR_W +: ADDR_W] =
      ADDR_W'(writeBank_q) * BANK_STRIDE + CH_OFFSET[g*ADDR_W +: ADDR_W];
  end

  assign write_req  = writeReq_q;
  assign write_bank = writeBank_q;
  assign read_bank  = readBank_q;
  assign read_valid = readValid_q;
  assign frame_swap = frameSwap_q;

`ifdef FRAME_DROP_CNT_EN
  logic [CH_NUM-1:0]      dropped;
  logic [CH_NUM-1:0][7:0] dropCnt_q, dropCnt_d;

  // A VSYNC on an enabled channel that is already busy or already finished
  // for this bank is lost; count it, saturating at 255.
  always_comb begin
    dropped   = vsPos & enMask_q & (maskAfterSwap | writeReq_q);
    dropCnt_d = dropCnt_q;
    for (int i = 0; i < CH_NUM; i++) begin
      if (dropped[i] && (dropCnt_q[i] != 8'hFF)) begin
        dropCnt_d[i] = dropCnt_q[i] + 8'd1;
      end
    end
  end

  // Counters are cleared only by reset.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_frame_order_gen_n.sv
// ---------------------------------------------------------------------------
// tb_frame_order_gen_n
// Drives two controllers (BUF_NUM=2 and BUF_NUM=3) with identical stimulus
// and compares them against a frame-level reference model: which channels
// are requesting, which are finished, how many rotations have happened and
// how many VSYNCs each channel has lost.
// ---------------------------------------------------------------------------
module tb_frame_order_gen_n;

  logic         clk = 1'b0;
  logic         rstN;
  logic [3:0]   imgVs;
  logic [3:0]   chEn;
  logic [3:0]   writeDone;

  logic [3:0]   reqA,  reqB;
  logic [111:0] addrA, addrB;
  logic         wbA,   rbA;
  logic [1:0]   wbB,   rbB;
  logic         rvA,   rvB;
  logic         fsA,   fsB;
`ifdef FRAME_DROP_CNT_EN
  logic [31:0]  dropA, dropB;
`endif

  localparam logic [27:0] CH_OFF [4] = '{28'h000_0000, 28'h000_0280,
                                         28'h003_8400, 28'h003_8680};

  // Reference model state
  logic [3:0] expReq;
  logic [3:0] expDone;
  logic [3:0] expEn;
  int         swaps;
  int         expDrop [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_order_gen_n #(.BUF_NUM(2)) dutA (
    .axi_aclk         (clk),
    .axi_aresetn      (rstN),
    .img_vs           (imgVs),
    .ch_en            (chEn),
    .write_req        (reqA),
    .write_done       (writeDone),
    .write_start_addr (addrA),
    .write_bank       (wbA),
    .read_bank        (rbA),
    .read_valid       (rvA),
    .frame_swap       (fsA)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt         (dropA)
`endif
  );

  frame_order_gen_n #(.BUF_NUM(3)) dutB (
    .axi_aclk         (clk),
    .axi_aresetn      (rstN),
    .img_vs           (imgVs),
    .ch_en            (chEn),
    .write_req        (reqB),
    .write_done       (writeDone),
    .write_start_addr (addrB),
    .write_bank       (wbB),
    .read_bank        (rbB),
    .read_valid       (rvB),
    .frame_swap       (fsB)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt         (dropB)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] expAddr(input int bank);
    logic [111:0] v;
    for (int i = 0; i < 4; i++) v[i*28 +: 28] = 28'(bank * 32'h0010_0000) + CH_OFF[i];
    return v;
  endfunction

  // ---- reference model ---------------------------------------------------
  task automatic modelReset();
    expReq = '0; expDone = '0; expEn = '0; swaps = 0;
    for (int i = 0; i < 4; i++) expDrop[i] = 0;
  endtask

  task automatic modelIdle();
    if (expReq == '0 && expDone == '0) expEn = chEn;
  endtask

  task automatic modelVsync(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i] && expEn[i]) begin
        if (!expReq[i] && !expDone[i]) expReq[i] = 1'b1;
        else if (expDrop[i] < 255) expDrop[i]++;
      end
    end
  endtask

  task automatic modelDone(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i] && expReq[i]) begin
        expReq[i]  = 1'b0;
        expDone[i] = 1'b1;
      end
    end
    if (expEn != '0 && (expDone | ~expEn) == 4'hF) begin
      swaps++;
      expDone = '0;
      expEn   = chEn;
    end
    modelIdle();
  endtask

  // ---- comparisons against the model -------------------------------------
  task automatic checkOutput(input string tag);
    logic [31:0] ed;
    check({tag, ".reqA"},  reqA,  expReq);
    check({tag, ".reqB"},  reqB,  expReq);
    check({tag, ".wbA"},   wbA,   swaps % 2);
    check({tag, ".wbB"},   wbB,   swaps % 3);
    check({tag, ".rbA"},   rbA,   (swaps == 0) ? 0 : (swaps - 1) % 2);
    check({tag, ".rbB"},   rbB,   (swaps == 0) ? 0 : (swaps - 1) % 3);
    check({tag, ".rvA"},   rvA,   swaps > 0);
    check({tag, ".rvB"},   rvB,   swaps > 0);
    check({tag, ".fsA"},   fsA,   0);
    check({tag, ".addrA"}, addrA, expAddr(swaps % 2));
    check({tag, ".addrB"}, addrB, expAddr(swaps % 3));
    for (int i = 0; i < 4; i++) ed[i*8 +: 8] = 8'(expDrop[i]);
`ifdef FRAME_DROP_CNT_EN
    check({tag, ".dropA"}, dropA, ed);
    check({tag, ".dropB"}, dropB, ed);
`endif
  endtask

  // ---- stimulus helpers ---------------------------------------------------
  task automatic applyStimulus(input logic [3:0] vs, input logic [3:0] dn);
    imgVs     = vs;
    writeDone = dn;
    tick(1);
    writeDone = '0;
  endtask

  task automatic vsyncPulse(input logic [3:0] m, input string tag);
    applyStimulus(m, 4'h0);
    tick(2);
    applyStimulus(4'h0, 4'h0);
    tick(4);
    modelVsync(m);
    checkOutput(tag);
  endtask

  task automatic donePulse(input logic [3:0] m, input string tag);
    applyStimulus(4'h0, m);
    tick(3);
    modelDone(m);
    checkOutput(tag);
  endtask

  task automatic setEnable(input logic [3:0] m);
    chEn = m;
    tick(2);
    modelIdle();
  endtask

  task automatic doReset(input logic [3:0] m);
    rstN = 1'b0; imgVs = '0; writeDone = '0; chEn = m;
    modelReset();
    tick(3);
    checkOutput("reset");
    rstN = 1'b1;
    tick(2);
    modelIdle();
  endtask

  initial begin
    logic [3:0] m;
    $display("[TB] frame_order_gen_n bench starting");
    rstN = 1'b0; imgVs = '0; writeDone = '0; chEn = 4'hF;
    modelReset();
    doReset(4'hF);

    // VSYNC latency: request appears right after the fourth edge
    imgVs = 4'hF;
    tick(3);
    check("vsLatencyEarly", reqA, 4'h0);
    tick(1);
    check("vsLatency", reqA, 4'hF);
    imgVs = 4'h0;
    tick(4);
    modelVsync(4'hF);
    checkOutput("vsAll");

    donePulse(4'h8, "done3");
    donePulse(4'h2, "done1");
    donePulse(4'h1, "done0");

    // Last done (ch2) with a ch0 VSYNC edge landing on the swap cycle
    imgVs = 4'h1;
    tick(2);
    writeDone = 4'h4;
    tick(1);
    writeDone = 4'h0;
    check("preSwapFs", fsA, 1'b0);
    check("preSwapWb", wbA, 1'b0);
    tick(1);
    check("swapFsA",   fsA, 1'b1);
    check("swapFsB",   fsB, 1'b1);
    check("swapWbA",   wbA, 1'b1);
    check("swapWbB",   wbB, 2'd1);
    check("swapRbA",   rbA, 1'b0);
    check("swapRv",    rvA, 1'b1);
    check("swapReq0",  reqA, 4'h1);
    check("swapAddr0", addrA[27:0], 28'h010_0000);
    check("swapAddr2", addrA[83:56], 28'h013_8400);
    tick(1);
    check("swapPulseWidth", fsA, 1'b0);
    imgVs = 4'h0;
    tick(3);
    modelDone(4'h4);
    modelVsync(4'h1);
    checkOutput("afterSwap");

    // Drops: VSYNC on a finished channel is ignored and counted
    vsyncPulse(4'hE, "vsRest");
    donePulse(4'h1, "done0b");
    vsyncPulse(4'h1, "dropFinished");
    for (int k = 0; k < 260; k++) begin
      applyStimulus(4'h1, 4'h0);
      tick(2);
      applyStimulus(4'h0, 4'h0);
      tick(3);
      modelVsync(4'h1);
    end
    checkOutput("dropSaturate");
    donePulse(4'hE, "doneRest");

    // Masked channels: only 0 and 2 take part
    doReset(4'h5);
    vsyncPulse(4'hF, "maskedVs");
    donePulse(4'h1, "maskedDone0");
    donePulse(4'h4, "maskedDone2");
    vsyncPulse(4'h2, "maskedCh1");

    // Everything disabled: nothing requests, nothing rotates
    donePulse(4'h5, "finishMasked");
    setEnable(4'h0);
    vsyncPulse(4'hF, "allOffVs");
    donePulse(4'hF, "allOffDone");
    setEnable(4'hF);

    // Randomised rounds, including mid-frame mask changes and stray dones
    for (int r = 0; r < 14; r++) begin
      setEnable(4'($urandom_range(1, 15)));
      for (int s = 0; s < 6; s++) begin
        case ($urandom_range(0, 3))
          0, 1:    vsyncPulse(4'($urandom_range(0, 15)), "rndVs");
          2:       donePulse(4'($urandom_range(0, 15)), "rndDone");
          default: setEnable(4'($urandom_range(0, 15)));
        endcase
      end
      m = expEn & ~expDone & ~expReq;
      if (m != 4'h0) vsyncPulse(m, "finVs");
      m = expEn & expReq;
      if (m != 4'h0) donePulse(m, "finDone");
    end

    // Asynchronous reset in the middle of a frame
    setEnable(4'hF);
    vsyncPulse(4'hF, "preRstVs");
    donePulse(4'h2, "preRstDone");
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncRst");
    tick(2);
    rstN = 1'b1;
    tick(2);
    modelIdle();
    vsyncPulse(4'h1, "postRstVs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
